// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, state encoding, trap causes and select encodings
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0000001;
    localparam logic [6:0] OP_RIMM  = 7'b0101001;
    localparam logic [6:0] OP_LUI   = 7'b1111001;
    localparam logic [6:0] OP_LOAD  = 7'b0101010;
    localparam logic [6:0] OP_STORE = 7'b1001010;
    localparam logic [6:0] OP_BRANCH = 7'b1010011;
    localparam logic [6:0] OP_JAL   = 7'b1111011;
    localparam logic [6:0] OP_JALR  = 7'b1011011;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_R, OP_RIMM, OP_LUI, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ack_timeout.sv
// rtl/ack_timeout.sv - wait-cycle counter flagging the last allowed cycle before a memory timeout
module ack_timeout #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // counts cycles already spent waiting; expired marks the final allowed cycle
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with retire counter and traps
module core_sequencer
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             branch_taken,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);
    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic       is_load, is_store, is_branch, is_jal, is_jalr;
    logic       waiting, wait_ack, expired;
    logic       retire, set_trap;
    logic [1:0] cause_d;

    assign opcode    = ir[6:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign state     = state_q;

    // one timer serves both memory phases; an ack restarts it for the next wait
    assign waiting  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wait_ack = (state_q == ST_FETCH) ? imem_ack : dmem_ack;

    ack_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting || wait_ack),
        .inc     (waiting && !wait_ack),
        .expired (expired)
    );

    // state register, instruction latch, retire counter and sticky trap
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ir          <= '0;
            instr_count <= '0;
            trap        <= 1'b0;
            trap_cause  <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && imem_ack) begin
                ir <= imem_rdata;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            if (set_trap) begin
                trap       <= 1'b1;
                trap_cause <= cause_d;
            end
        end
    end

    // next-state and phase strobes; reqs depend on state only, never on acks
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        wb_sel   = WB_ALU;
        pc_sel   = PC_PLUS4;
        retire   = 1'b0;
        set_trap = 1'b0;
        cause_d  = CAUSE_NONE;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d  = ST_TRAP;
                    set_trap = 1'b1;
                    cause_d  = CAUSE_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (is_legal_opcode(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d  = ST_TRAP;
                    set_trap = 1'b1;
                    cause_d  = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
                    retire = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (expired) begin
                    state_d  = ST_TRAP;
                    set_trap = 1'b1;
                    cause_d  = CAUSE_DMEM_TO;
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                if (is_load)               wb_sel = WB_MEM;
                else if (is_jal || is_jalr) wb_sel = WB_PC4;
                if (is_jal)       pc_sel = PC_IMM;
                else if (is_jalr) pc_sel = PC_ALU;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // a retiring instruction always finishes; run only decides whether to fetch again
        if (retire) begin
            state_d = run ? ST_FETCH : ST_IDLE;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;
    logic        clk, rst, run;
    logic        imem_req, imem_ack;
    logic [31:0] imem_rdata, ir;
    logic        dmem_req, dmem_we, dmem_ack, branch_taken;
    logic        reg_we, pc_we, trap;
    logic [1:0]  wb_sel, pc_sel, trap_cause;
    logic [2:0]  state;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;
    int req_cycles;

    core_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .branch_taken (branch_taken),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .state        (state),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // call in FETCH; returns in DECODE with ir loaded
    task automatic issue(input logic [31:0] instr);
        imem_ack   = 1'b1;
        imem_rdata = instr;
        tick();
        imem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        dmem_ack = 1'b0; branch_taken = 1'b0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_trap", {30'd0, trap_cause} | 32'(trap), 32'd0);
        check("rst_strobes", {28'd0, imem_req, dmem_req, reg_we, pc_we}, 32'd0);

        // R-type with zero-wait fetch
        rst = 1'b0; run = 1'b1;
        tick();
        check("r_fetch", 32'(state), 32'd1);
        check("r_imem_req", 32'(imem_req), 32'd1);
        issue(32'h0000_0001);
        check("r_decode", 32'(state), 32'd2);
        check("r_ir", ir, 32'h1);
        tick();
        check("r_exec", 32'(state), 32'd3);
        check("r_exec_regwe", 32'(reg_we), 32'd0);
        tick();
        check("r_wb", 32'(state), 32'd5);
        check("r_wb_strobes", {30'd0, reg_we, pc_we}, 32'd3);
        check("r_wb_sels", {28'd0, wb_sel, pc_sel}, 32'd0);
        check("r_wb_count", instr_count, 32'd0);
        tick();
        check("r_retire_state", 32'(state), 32'd1);
        check("r_retire_count", instr_count, 32'd1);
        check("r_regwe_pulse", 32'(reg_we), 32'd0);

        // load with three wait cycles, ack on the limit cycle
        issue(32'h0000_002A);
        tick(); tick();
        check("ld_mem", 32'(state), 32'd4);
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            #1;
            req_cycles += int'(dmem_req);
            check("ld_dmem_we", 32'(dmem_we), 32'd0);
            if (i == 3) check("ld_no_pcwe", 32'(pc_we), 32'd0);
            tick();
        end
        dmem_ack = 1'b0;
        check("ld_req_cycles", 32'(req_cycles), 32'd4);
        check("ld_wb", 32'(state), 32'd5);
        check("ld_wb_sel", 32'(wb_sel), 32'd1);
        check("ld_regwe", 32'(reg_we), 32'd1);
        check("ld_trap", 32'(trap), 32'd0);
        tick();
        check("ld_count", instr_count, 32'd2);

        // branch taken then not taken
        for (int t = 1; t >= 0; t--) begin
            issue(32'h0000_0053);
            tick();
            branch_taken = t[0];
            #1;
            check("br_pcwe", 32'(pc_we), 32'd1);
            check("br_pcsel", 32'(pc_sel), 32'(t));
            check("br_regwe", 32'(reg_we), 32'd0);
            tick();
            check("br_next", 32'(state), 32'd1);
        end
        branch_taken = 1'b0;
        check("br_count", instr_count, 32'd4);

        // store with ack on the last allowed cycle
        issue(32'h0000_004A);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            #1;
            if (i == 0) check("st_dmem_we", 32'(dmem_we), 32'd1);
            if (i == 3) check("st_pcwe", {29'd0, pc_we, pc_sel}, 32'h4);
            tick();
        end
        dmem_ack = 1'b0;
        check("st_next", 32'(state), 32'd1);
        check("st_trap", 32'(trap), 32'd0);
        check("st_count", instr_count, 32'd5);

        // run dropped during a load's MEM phase
        issue(32'h0000_002A);
        tick(); tick();
        run = 1'b0;
        tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("rd_wb", 32'(state), 32'd5);
        check("rd_wb_sel", 32'(wb_sel), 32'd1);
        tick();
        check("rd_idle", 32'(state), 32'd0);
        check("rd_count", instr_count, 32'd6);
        tick();
        check("rd_stay_idle", {29'd0, state} | 32'(imem_req), 32'd0);

        // illegal opcode traps and absorbs
        run = 1'b1;
        tick();
        issue(32'h0000_007F);
        check("il_decode", 32'(state), 32'd2);
        tick();
        check("il_trap_state", 32'(state), 32'd7);
        check("il_trap", {29'd0, trap, trap_cause}, 32'h5);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        repeat (3) tick();
        check("il_absorb", 32'(state), 32'd7);
        check("il_quiet", {28'd0, imem_req, dmem_req, reg_we, pc_we}, 32'd0);
        check("il_ir_hold", ir, 32'h7F);
        check("il_count_hold", instr_count, 32'd6);
        imem_ack = 1'b0; dmem_ack = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_trap", {29'd0, trap, trap_cause}, 32'd0);
        check("rst2_count", instr_count, 32'd0);

        // fetch timeout
        tick();
        repeat (3) tick();
        check("ito_last", 32'(state), 32'd1);
        tick();
        check("ito_trap", {29'd0, trap, trap_cause}, 32'h6);
        check("ito_state", 32'(state), 32'd7);

        // store timeout
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        issue(32'h0000_004A);
        tick(); tick();
        repeat (3) tick();
        check("sto_last", 32'(state), 32'd4);
        tick();
        check("sto_trap", {29'd0, trap, trap_cause}, 32'h7);
        check("sto_state", 32'(state), 32'd7);

        // LUI, JAL, JALR writeback selects
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        issue(32'h0000_0079);
        tick(); tick();
        check("lui_sels", {28'd0, wb_sel, pc_sel}, 32'h0);
        tick();
        issue(32'h0000_007B);
        tick(); tick();
        check("jal_sels", {28'd0, wb_sel, pc_sel}, 32'h9);
        tick();
        issue(32'h0000_005B);
        tick(); tick();
        check("jalr_sels", {28'd0, wb_sel, pc_sel}, 32'hA);
        tick();
        check("j_count", instr_count, 32'd3);
        check("j_fetch_req", 32'(imem_req), 32'd1);

        // reset mid-FETCH
        rst = 1'b1;
        tick();
        check("mf_state", 32'(state), 32'd0);
        check("mf_quiet", {28'd0, imem_req, dmem_req, reg_we, pc_we}, 32'd0);
        check("mf_count", instr_count, 32'd0);
        check("mf_ir", ir, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
